uart_tx_scheduler: RTL

- Sequences the UART transmitter on behalf of the CPU.
- Buffers bytes written by the peripheral controller (PCH) on its SendTx strobe into a FIFO.
- Issues one send pulse per byte to the UART_TxRx block, and waits for that block's busy flag to rise and then fall before issuing the next byte.
- Sits between the PCH and UART_TxRx, replacing direct CPU polling of UART_BUSY per byte.

---
 rtl/uart_tx_scheduler_if.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Groups the PCH write side, the UART_TxRx handshake and the status flags of
// the UART transmit scheduler into one bundle.
//   slave  : the scheduler (consumes wr_*/clr_overflow/uart_busy, drives rest)
//   master : the PCH / UART environment driving the scheduler
// Signals:
//   wr_en, wr_data    one-cycle write strobe and byte from the PCH
//   clr_overflow      clears the sticky overflow flag
//   uart_busy         UART_BUSY from UART_TxRx
//   send_tx, tx_byte  send request and byte towards UART_TxRx
//   fifo_count/full/empty, overflow, tx_active   status
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              clr_overflow;
   logic              uart_busy;
   logic              send_tx;
   logic [7:0]        tx_byte;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow;
   logic              tx_active;

   modport slave (
      input  wr_en, wr_data, clr_overflow, uart_busy,
      output send_tx, tx_byte, fifo_count, fifo_full, fifo_empty, overflow, tx_active
   );

   modport master (
      output wr_en, wr_data, clr_overflow, uart_busy,
      input  send_tx, tx_byte, fifo_count, fifo_full, fifo_empty, overflow, tx_active
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Buffers bytes written by the PCH into a circular FIFO and feeds them one at a
// time to UART_TxRx: a send_tx burst per byte, then waits for uart_busy to rise
// and fall before the next byte. If busy never rises the same byte is re-sent
// after BUSY_TIMEOUT cycles.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    uart_tx_scheduler_if.slave (write side, UART handshake, status)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int DEPTH        = 8,
   parameter int ADDR_W       = 3,
   parameter int SEND_CYCLES  = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input logic               clk,
   input logic               reset,
   uart_tx_scheduler_if.slave bus
);

   localparam int SEND_W = (SEND_CYCLES > 1) ? $clog2(SEND_CYCLES) : 1;
   localparam int TO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   localparam logic [SEND_W-1:0] SEND_LAST = SEND_W'(SEND_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_HI,
      WAIT_LO
   } state_e;

   // FIFO
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, empty_q, overflow_q;
   logic              push, pop, drop;

   // Sequencer
   state_e            state_q;
   logic [SEND_W-1:0] send_cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              send_tx_q, tx_active_q;
   logic [7:0]        tx_byte_q;

   // A pop happens only from IDLE; a write into a full FIFO still succeeds
   // when the head leaves on the same edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      pop     = (state_q == IDLE) && !empty_q;
      push    = bus.wr_en && ((count_q != DEPTH_C) || pop);
      drop    = bus.wr_en && !push;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; entries are only ever read behind
   // a non-zero count, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
         // A drop on the same edge as a clear keeps the flag set.
         if (drop)                  overflow_q <= 1'b1;
         else if (bus.clr_overflow) overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         send_cnt_q  <= '0;
         to_cnt_q    <= '0;
         send_tx_q   <= 1'b0;
         tx_byte_q   <= 8'h00;
         tx_active_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  tx_byte_q   <= mem[rd_ptr_q];
                  send_tx_q   <= 1'b1;
                  send_cnt_q  <= '0;
                  tx_active_q <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (send_cnt_q == SEND_LAST) begin
                  send_tx_q <= 1'b0;
                  to_cnt_q  <= '0;
                  state_q   <= WAIT_HI;
               end else begin
                  send_cnt_q <= send_cnt_q + SEND_W'(1);
               end
            end
            WAIT_HI: begin
               if (bus.uart_busy) begin
                  state_q <= WAIT_LO;
               end else if (to_cnt_q == TO_LAST) begin
                  // UART never acknowledged: re-send the same byte.
                  send_tx_q  <= 1'b1;
                  send_cnt_q <= '0;
                  state_q    <= SEND;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            WAIT_LO: begin
               if (!bus.uart_busy) begin
                  tx_active_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.send_tx    = send_tx_q;
   assign bus.tx_byte    = tx_byte_q;
   assign bus.fifo_count = count_q;
   assign bus.fifo_full  = full_q;
   assign bus.fifo_empty = empty_q;
   assign bus.overflow   = overflow_q;
   assign bus.tx_active  = tx_active_q;

endmodule
